// File: rtl/fetch_aligner.sv
// fetch_aligner: splits aligned 32-bit fetch words into 16/32-bit instructions and tracks their PC
module fetch_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_compressed_o
);
  logic [31:1] pc_q, pc_d;
  logic [15:0] hw_q, hw_d;
  logic        hw_vld_q, hw_vld_d;
  logic        skip_q, skip_d;
  logic        hw_c, instr_fire, fetch_fire;
  logic        unused_pc_lsb;
  assign unused_pc_lsb = flush_pc_i[0];
  // a buffered compressed halfword can be emitted without any new fetch data
  assign hw_c = hw_vld_q && hw_q[1:0] != 2'b11;
  assign instr_fire = instr_valid_o && instr_ready_i;
  assign fetch_fire = fetch_valid_i && fetch_ready_o;
  assign instr_pc_o = {pc_q, 1'b0};
  // select the instruction from the buffered halfword and/or the incoming word
  always_comb begin
    instr_o = hw_vld_q ? (hw_c ? {16'h0, hw_q} : {fetch_rdata_i[15:0], hw_q})
                       : (fetch_rdata_i[1:0] != 2'b11 ? {16'h0, fetch_rdata_i[15:0]} : fetch_rdata_i);
    instr_is_compressed_o = instr_o[1:0] != 2'b11;
    instr_valid_o = !flush_i && !skip_q && (hw_c || fetch_valid_i);
    fetch_ready_o = !flush_i && (skip_q || (!hw_c && instr_ready_i));
  end
  // next-state: flush redirects, skip drops a low half, otherwise advance on instr transfer
  always_comb begin
    pc_d = pc_q;
    hw_d = hw_q;
    hw_vld_d = hw_vld_q;
    skip_d = skip_q;
    if (flush_i) begin
      pc_d = flush_pc_i[31:1];
      hw_vld_d = 1'b0;
      skip_d = flush_pc_i[1];
    end else if (skip_q) begin
      if (fetch_fire) begin
        hw_d = fetch_rdata_i[31:16];
        hw_vld_d = 1'b1;
        skip_d = 1'b0;
      end
    end else if (instr_fire) begin
      pc_d = pc_q + (instr_is_compressed_o ? 31'd1 : 31'd2);
      hw_d = fetch_fire ? fetch_rdata_i[31:16] : hw_q;
      hw_vld_d = fetch_fire && (hw_vld_q || instr_is_compressed_o);
    end
  end
  // state registers with asynchronous reset to the boot address
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= BOOT_ADDR[31:1];
      hw_q <= 16'h0;
      hw_vld_q <= 1'b0;
      skip_q <= BOOT_ADDR[1];
    end else begin
      pc_q <= pc_d;
      hw_q <= hw_d;
      hw_vld_q <= hw_vld_d;
      skip_q <= skip_d;
    end
  end
endmodule
